// File: rtl/acc_seq_adder_pkg.sv
// Shared types and default widths for the sequential multi-operand accumulator.
package acc_seq_adder_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned CNT_W_DEF = 4;

  // Accumulator FSM: collecting beats, or presenting a finished result
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage : acc_seq_adder_pkg

// File: rtl/rca_nbits.sv
// n-bit ripple-carry adder: s = x + y + c_in, carry-out on c_out.
module rca_nbits #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         c_in,
  output logic [n-1:0] s,
  output logic         c_out
);

  logic [n:0] c;

  assign c[0] = c_in;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < int'(n); i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign c_out = c[n];

endmodule : rca_nbits

// File: rtl/acc_seq_adder.sv
// Packet accumulator: sums a valid/ready operand stream through the ripple-carry
// adder and reports the modular sum, carry count, beat count and a sticky
// saturation flag once the last beat has been taken.
module acc_seq_adder
  import acc_seq_adder_pkg::*;
#(
  parameter int unsigned n     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [n-1:0]     acc;
  logic [CNT_W-1:0] carries;
  logic [CNT_W-1:0] beats;
  logic             ovf;

  logic [n-1:0]     add_s;
  logic             add_c;
  logic             accept;
  logic             carry_sat;
  logic             beat_sat;

  // Running total plus the incoming operand; no carry-in
  rca_nbits #(
    .n (n)
  ) u_rca (
    .x     (acc),
    .y     (in_data),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  // Ready drops the moment reset asserts so nothing is taken during reset
  assign in_ready  = (state == ACCUM) & ~rst;
  assign accept    = in_valid & in_ready;
  assign carry_sat = add_c & (carries == CNT_MAX);
  assign beat_sat  = (beats == CNT_MAX);

  // FSM, accumulator and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      acc       <= '0;
      carries   <= '0;
      beats     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= add_s;
            if (!carry_sat) carries <= carries + CNT_W'(add_c);
            if (!beat_sat)  beats   <= beats + CNT_W'(1);
            ovf <= ovf | carry_sat | beat_sat;
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            acc       <= '0;
            carries   <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_beats   = beats;
  assign out_ovf     = ovf;

endmodule : acc_seq_adder

// File: doc/acc_seq_adder.md
Name: acc_seq_adder

Overview:
- Sequential multi-operand accumulator that supplies operands to the team's n-bit ripple-carry adder and captures its sum and carry-out every cycle.
- Accepts a stream of n-bit operands over a valid/ready handshake. Each packet is terminated by `in_last`.
- Produces the packet total as an n-bit modular sum plus a count of carry-outs, so the full sum = carries·2^n + sum.
- Sits between an operand source and any result consumer, with valid/ready on both sides.

Parameters:
- n, 8, operand/sum width in bits (≥2)
- CNT_W, 4, width of the carry counter and beat counter (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  n  operand
- in_last  input  1  final beat of packet; qualified by in_valid & in_ready
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer accepts result
- out_sum  output  n  packet sum modulo 2^n
- out_carries  output  CNT_W  number of adder carry-outs in the packet (saturating)
- out_beats  output  CNT_W  beats in the packet (saturating)
- out_ovf  output  1  sticky: a counter saturated during this packet

Behaviour:
- State machine with two states:
  - ACCUM: accepting beats.
  - HOLD: result presented.
- Register reset values, all applied asynchronously on rst:
  - state = ACCUM, out_valid = 0, acc (drives out_sum) = 0, carries = 0, beats = 0, ovf = 0.
- in_ready = (state == ACCUM) & ~rst. It is 0 while rst is high and 1 in the first cycle after release.
- out_valid = (state == HOLD), registered.
- Accept condition: in_valid & in_ready.
- On accept:
  - acc ← adder.s, where adder inputs are x = acc, y = in_data, C_in = 0.
  - carries ← carries + adder.C_out. Saturates at 2^CNT_W−1; an attempted increment past max sets ovf.
  - beats ← beats + 1. Saturates the same way; an attempted increment past max sets ovf.
  - If in_last: state ← HOLD.
- Output timing:
  - out_valid rises the cycle after the last beat is accepted.
  - out_* reflect all beats, including the last beat.
- HOLD:
  - in_ready = 0; in_valid and in_data are ignored.
  - out_sum, out_carries, out_beats and out_ovf are stable until the handshake completes.
- On out_valid & out_ready:
  - acc, carries, beats and ovf ← 0.
  - state ← ACCUM, so in_ready = 1 on the next cycle.
  - A new packet cannot be accepted in the same cycle as the result handshake: there is a minimum 1-cycle gap between packets.
- Single-beat packet (in_last on the first beat): out_sum = in_data, out_beats = 1.
- No beat accepted (in_valid low): all registers hold.
- in_last with in_valid low: ignored.
- rst mid-packet or mid-HOLD:
  - Partial totals are discarded and out_valid drops immediately.
  - No result is emitted for the aborted packet.
- Throughput: one beat per cycle in ACCUM. Adder path latency: zero cycles (combinational). Result latency: 1 cycle after the last beat.

Decomposition:
- Shared package: state encoding (ACCUM, HOLD) and default widths N_DEF = 8, CNT_W_DEF = 4.
- One sub-module: instantiate the existing n-bit ripple-carry adder rca_nbits with C_in tied to 0. Its carry-out feeds the carry counter.
- FSM, counters and output registers live in acc_seq_adder.

Test Plan:
- Reset: hold rst 3 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, out_sum = 0x00. After release, in_ready = 1 and no beat is accepted during reset.
- Basic packet: 0x10, 0x20, 0x30 (last) on consecutive cycles → out_valid the next cycle with out_sum = 0x60, out_carries = 0, out_beats = 3, out_ovf = 0.
- Carry: 0xFF, 0x01, 0xFF (last) → out_sum = 0xFF, out_carries = 1, out_beats = 3 (total 511).
- Saturation: 17 beats of 0xFF, last on the 17th → out_sum = 0xEF, out_carries = 15, out_beats = 15, out_ovf = 1.
- Backpressure: out_ready = 0 for 5 cycles after out_valid, with in_valid = 1 and random in_data → outputs stable and in_ready = 0 throughout. Raise out_ready → in_ready = 1 the next cycle. A following packet 0x05 (last) gives out_sum = 0x05, out_ovf = 0.
- Reset mid-packet: accept 0x40, 0x40, then pulse rst → out_valid stays 0. The next packet 0x01 (last) gives out_sum = 0x01, out_beats = 1, out_carries = 0.
